dac_spi_tx: RTL
===============

DAC_SPI_TX -- requirements
Module: dac_spi_tx

Interface
REQ-001 Parameter CLK_DIV, default 5: clk cycles per SCLK half-period (5 gives 10 MHz SCLK from 100 MHz clk); legal range 2..255.
REQ-002 Parameter CS_GAP, default 5: clk cycles CS_n is held high between frames and before LDAC.
REQ-003 Parameter LDAC_CYCLES, default 5: clk cycles LDAC_n is held low.
REQ-004 clk  input  1  system clock, 100 MHz.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 clk_sampling  input  1  one-clk-wide 50 kHz sample strobe.
REQ-007 enableA  input  1  channel A active; low means channel A is shut down.
REQ-008 enableB  input  1  channel B active; low means channel B is shut down.
REQ-009 dacA_word  input  12  unsigned DAC code for channel A.
REQ-010 dacB_word  input  12  unsigned DAC code for channel B.
REQ-011 cs_n  output  1  DAC chip select, active low.
REQ-012 sclk  output  1  SPI clock, mode 0 (idles low; DAC samples on rising edge).
REQ-013 mosi  output  1  serial data, MSB first.
REQ-014 ldac_n  output  1  DAC output latch strobe, active low.
REQ-015 busy  output  1  high from the first cycle after trigger until return to IDLE.
REQ-016 overrun  output  1  one-clk pulse when clk_sampling arrives while busy.

Function
REQ-017 States: IDLE, FRAME_A, GAP_A, FRAME_B, GAP_B, LDAC, and back to IDLE; all outputs are registered.
REQ-018 Trigger: clk_sampling high in IDLE at cycle T captures dacA_word, dacB_word, enableA and enableB into shadow registers; input changes after T do not affect the transfer in progress.
REQ-019 Frame A word: {1'b0, 1'b0, 1'b1, enableA, dacA_word} (A/B select=0, don't-care=0, GA_n=1 for 1x gain, SHDN_n=enable).
REQ-020 Frame B word: {1'b1, 1'b0, 1'b1, enableB, dacB_word}.
REQ-021 Frame timing: at T+1, cs_n=0, sclk=0 and mosi=bit15.
REQ-022 Each bit lasts 2*CLK_DIV cycles: sclk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
REQ-023 mosi changes only in the cycle sclk goes low (or at frame start), and is stable throughout each high phase.
REQ-024 A frame has exactly 16 sclk rising edges.
REQ-025 After the 16th high phase, sclk=0 and cs_n stays low for CLK_DIV hold cycles, then cs_n=1.
REQ-026 cs_n low duration per frame: 33*CLK_DIV cycles (165 at default).
REQ-027 GAP_A / GAP_B: cs_n=1, sclk=0 and mosi=0 for CS_GAP cycles.
REQ-028 LDAC: ldac_n=0 for LDAC_CYCLES cycles; cs_n stays 1 throughout; then IDLE, with busy=0 in the first IDLE cycle.
REQ-029 Total busy duration at default parameters: 165+5+165+5+5 = 345 cycles.
REQ-030 Transfers are always A then B, both frames sent every trigger; a disabled channel still sends its frame, with SHDN_n=0.
REQ-031 clk_sampling while busy: the strobe is dropped (not queued), overrun pulses for 1 cycle, and the transfer in progress continues unchanged.
REQ-032 clk_sampling in the same cycle busy falls (first IDLE cycle) is a valid trigger.
REQ-033 Bit counter is 4-bit with terminal count 0; the divider counter is 8-bit and reloads at CLK_DIV-1.
REQ-034 Input words are zero-extended/unsigned; no arithmetic is performed on the data.

Reset
REQ-035 reset high at any clk edge, including mid-frame, forces the following within one cycle: state=IDLE, cs_n=1, sclk=0, mosi=0, ldac_n=1, busy=0, overrun=0, shadow registers=0.
REQ-036 A truncated frame is abandoned on reset and no LDAC pulse is issued for it.
REQ-037 clk_sampling is ignored while reset is high.
REQ-038 The first trigger after reset is accepted in the first cycle reset is low.

Verification
REQ-039 dacA_word=12'hABC, dacB_word=12'h123, both enables=1, strobe -> frame A bits 16'h3ABC, frame B bits 16'hB123 captured on sclk rising edges, then ldac_n low for 5 cycles, busy high for 345 cycles.
REQ-040 enableA=0, enableB=1, words 12'hFFF/12'h000 -> frame A 16'h2FFF, frame B 16'hB000.
REQ-041 Timing check at default parameters: cs_n low exactly 165 cycles per frame, sclk period 10 cycles, cs_n high exactly 5 cycles between frames, no sclk edge while cs_n=1.
REQ-042 Second strobe at T+100 -> overrun=1 for one cycle, frames unaltered; strobe at the first IDLE cycle -> new transfer starts the next cycle.
REQ-043 reset asserted at T+80 (mid frame A) -> next cycle cs_n=1, sclk=0, busy=0, no ldac_n pulse; a fresh strobe afterwards produces correct frames.
REQ-044 dacA_word changed at T+2 -> transmitted frame A still carries the value present at T.

Source files
------------

// File: rtl/dac_spi_tx_if.sv
// Bus bundle between a sample source and the dual-channel DAC SPI transmitter.
// The master side supplies sample words and strobes; the slave side drives the DAC pins.
interface dac_spi_tx_if;
    logic        clk_sampling;
    logic        enableA;
    logic        enableB;
    logic [11:0] dacA_word;
    logic [11:0] dacB_word;
    logic        cs_n;
    logic        sclk;
    logic        mosi;
    logic        ldac_n;
    logic        busy;
    logic        overrun;

    modport master (
        output clk_sampling, enableA, enableB, dacA_word, dacB_word,
        input  cs_n, sclk, mosi, ldac_n, busy, overrun
    );

    modport slave (
        input  clk_sampling, enableA, enableB, dacA_word, dacB_word,
        output cs_n, sclk, mosi, ldac_n, busy, overrun
    );
endinterface

// File: rtl/dac_spi_tx.sv
// Dual-channel SPI DAC transmitter: on each sample strobe it sends frame A, then frame B,
// then pulses LDAC_n so that both channels update together. SPI mode 0, MSB first.
// All DAC pins are driven straight from flops.
module dac_spi_tx #(
    parameter int CLK_DIV     = 5,
    parameter int CS_GAP      = 5,
    parameter int LDAC_CYCLES = 5
) (
    input  logic         clk,
    input  logic         reset,
    dac_spi_tx_if.slave  dac
);

    typedef enum logic [2:0] {
        IDLE,
        FRAME_A,
        GAP_A,
        FRAME_B,
        GAP_B,
        LDAC
    } state_t;

    localparam logic [7:0] DIV_RELOAD  = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_RELOAD  = 8'(CS_GAP - 1);
    localparam logic [7:0] LDAC_RELOAD = 8'(LDAC_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [3:0]  bit_q, bit_d;
    logic        hold_q, hold_d;
    logic [11:0] dacA_q, dacA_d;
    logic [11:0] dacB_q, dacB_d;
    logic        enA_q, enA_d;
    logic        enB_q, enB_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        ldac_n_q, ldac_n_d;
    logic        busy_q, busy_d;
    logic        overrun_q, overrun_d;

    logic [15:0] wordA;
    logic [15:0] wordB;
    logic [15:0] curWord;
    logic [3:0]  nextIdx;

    // Frame layout: {A/B select, don't-care, GA_n (1x gain), SHDN_n, 12-bit code}.
    assign wordA   = {1'b0, 1'b0, 1'b1, enA_q, dacA_q};
    assign wordB   = {1'b1, 1'b0, 1'b1, enB_q, dacB_q};
    assign curWord = (state_q == FRAME_B) ? wordB : wordA;
    assign nextIdx = bit_q - 4'd1;

    // Next-state and next-output logic; a single down-counter times every phase.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        hold_d    = hold_q;
        dacA_d    = dacA_q;
        dacB_d    = dacB_q;
        enA_d     = enA_q;
        enB_d     = enB_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ldac_n_d  = ldac_n_q;
        overrun_d = dac.clk_sampling && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (dac.clk_sampling) begin
                    dacA_d  = dac.dacA_word;
                    dacB_d  = dac.dacB_word;
                    enA_d   = dac.enableA;
                    enB_d   = dac.enableB;
                    state_d = FRAME_A;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    mosi_d  = wordA[15];
                    bit_d   = 4'd15;
                    div_d   = DIV_RELOAD;
                    hold_d  = 1'b0;
                end
            end
            FRAME_A, FRAME_B: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else if (hold_q) begin
                    hold_d  = 1'b0;
                    cs_n_d  = 1'b1;
                    mosi_d  = 1'b0;
                    div_d   = GAP_RELOAD;
                    state_d = (state_q == FRAME_A) ? GAP_A : GAP_B;
                end else if (!sclk_q) begin
                    sclk_d = 1'b1;
                    div_d  = DIV_RELOAD;
                end else begin
                    sclk_d = 1'b0;
                    div_d  = DIV_RELOAD;
                    if (bit_q == 4'd0) begin
                        hold_d = 1'b1;
                    end else begin
                        bit_d  = nextIdx;
                        mosi_d = curWord[nextIdx];
                    end
                end
            end
            GAP_A: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else begin
                    state_d = FRAME_B;
                    cs_n_d  = 1'b0;
                    mosi_d  = wordB[15];
                    bit_d   = 4'd15;
                    div_d   = DIV_RELOAD;
                end
            end
            GAP_B: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else begin
                    state_d  = LDAC;
                    ldac_n_d = 1'b0;
                    div_d    = LDAC_RELOAD;
                end
            end
            LDAC: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else begin
                    state_d  = IDLE;
                    ldac_n_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counters, shadow registers and registered pins; reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            div_q     <= 8'd0;
            bit_q     <= 4'd0;
            hold_q    <= 1'b0;
            dacA_q    <= 12'd0;
            dacB_q    <= 12'd0;
            enA_q     <= 1'b0;
            enB_q     <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ldac_n_q  <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            hold_q    <= hold_d;
            dacA_q    <= dacA_d;
            dacB_q    <= dacB_d;
            enA_q     <= enA_d;
            enB_q     <= enB_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ldac_n_q  <= ldac_n_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign dac.cs_n    = cs_n_q;
    assign dac.sclk    = sclk_q;
    assign dac.mosi    = mosi_q;
    assign dac.ldac_n  = ldac_n_q;
    assign dac.busy    = busy_q;
    assign dac.overrun = overrun_q;

endmodule
